// File: rtl/mpc_response_rx.sv
// MPC response receiver: tracks link health from the demuxed accept bits and
// matches each transmitted LCT frame to its response after a programmable latency.
module mpc_response_rx #(
    parameter int CNT_W  = 16,
    parameter int UP_CNT = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       mpc_rx_1st,
    input  logic [1:0]       mpc_rx_2nd,
    input  logic             mpc_xmit,
    input  logic [3:0]       mpc_rx_delay,
    input  logic             count_clr,
    output logic             mpc_vpf,
    output logic [1:0]       mpc_accept,
    output logic [1:0]       mpc_reserved,
    output logic             link_up,
    output logic [CNT_W-1:0] cnt_xmit,
    output logic [CNT_W-1:0] cnt_acc0,
    output logic [CNT_W-1:0] cnt_acc1,
    output logic [CNT_W-1:0] cnt_lost
);

    localparam int RUN_W = (UP_CNT < 2) ? 1 : $clog2(UP_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(UP_CNT - 1);

    typedef enum logic [1:0] {
        DOWN = 2'b00,
        WAIT = 2'b01,
        UP   = 2'b10
    } link_state_t;

    link_state_t      state_r;
    logic [RUN_W-1:0] run_r;
    logic [1:0]       idle_cnt_r;
    logic             link_up_r;
    logic [15:0]      tag_r;
    logic             vpf_r;
    logic [1:0]       accept_r;
    logic [1:0]       reserved_r;
    logic [CNT_W-1:0] cnt_xmit_r;
    logic [CNT_W-1:0] cnt_acc0_r;
    logic [CNT_W-1:0] cnt_acc1_r;
    logic [CNT_W-1:0] cnt_lost_r;

    logic       idle_s;
    logic [3:0] tap_idx_s;
    logic       tap_s;
    logic       load_s;
    logic       lost_s;
    logic       acc0_s;
    logic       acc1_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] r;
        if (en && (v != {CNT_W{1'b1}})) begin
            r = v + CNT_W'(1'b1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Idle detection, response tap selection and per-clock event qualifiers
    always_comb begin
        idle_s = ({mpc_rx_2nd, mpc_rx_1st} == 4'b1111);
        if (mpc_rx_delay == 4'd0) begin
            tap_idx_s = 4'd0;
        end else begin
            tap_idx_s = mpc_rx_delay - 4'd1;
        end
        tap_s  = tag_r[tap_idx_s];
        load_s = tap_s && (state_r == UP);
        lost_s = tap_s && (state_r != UP);
        acc0_s = load_s && mpc_rx_1st[0];
        acc1_s = load_s && mpc_rx_1st[1];
    end

    // Link FSM: run of clean clocks to come up, four idle clocks to drop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= DOWN;
            run_r      <= {RUN_W{1'b0}};
            idle_cnt_r <= 2'd0;
            link_up_r  <= 1'b0;
        end else begin
            case (state_r)
                DOWN: begin
                    if (!idle_s) begin
                        if (UP_CNT <= 1) begin
                            state_r    <= UP;
                            idle_cnt_r <= 2'd0;
                            link_up_r  <= 1'b1;
                        end else begin
                            state_r <= WAIT;
                            run_r   <= RUN_W'(1'b1);
                        end
                    end
                end
                WAIT: begin
                    if (idle_s) begin
                        state_r <= DOWN;
                        run_r   <= {RUN_W{1'b0}};
                    end else if (run_r == RUN_LAST) begin
                        state_r    <= UP;
                        run_r      <= {RUN_W{1'b0}};
                        idle_cnt_r <= 2'd0;
                        link_up_r  <= 1'b1;
                    end else begin
                        run_r <= run_r + RUN_W'(1'b1);
                    end
                end
                UP: begin
                    if (idle_s) begin
                        if (idle_cnt_r == 2'd3) begin
                            state_r    <= DOWN;
                            idle_cnt_r <= 2'd0;
                            run_r      <= {RUN_W{1'b0}};
                            link_up_r  <= 1'b0;
                        end else begin
                            idle_cnt_r <= idle_cnt_r + 2'd1;
                        end
                    end else begin
                        idle_cnt_r <= 2'd0;
                    end
                end
                default: begin
                    state_r    <= DOWN;
                    run_r      <= {RUN_W{1'b0}};
                    idle_cnt_r <= 2'd0;
                    link_up_r  <= 1'b0;
                end
            endcase
        end
    end

    // Transmit tag pipeline and response capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_r      <= 16'h0000;
            vpf_r      <= 1'b0;
            accept_r   <= 2'b00;
            reserved_r <= 2'b00;
        end else begin
            tag_r <= {tag_r[14:0], mpc_xmit};
            vpf_r <= load_s;
            if (load_s) begin
                accept_r   <= mpc_rx_1st;
                reserved_r <= mpc_rx_2nd;
            end
        end
    end

    // Saturating event counters; clear wins over a same-clock increment
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_xmit_r <= {CNT_W{1'b0}};
            cnt_acc0_r <= {CNT_W{1'b0}};
            cnt_acc1_r <= {CNT_W{1'b0}};
            cnt_lost_r <= {CNT_W{1'b0}};
        end else if (count_clr) begin
            cnt_xmit_r <= {CNT_W{1'b0}};
            cnt_acc0_r <= {CNT_W{1'b0}};
            cnt_acc1_r <= {CNT_W{1'b0}};
            cnt_lost_r <= {CNT_W{1'b0}};
        end else begin
            cnt_xmit_r <= sat_inc(cnt_xmit_r, mpc_xmit);
            cnt_acc0_r <= sat_inc(cnt_acc0_r, acc0_s);
            cnt_acc1_r <= sat_inc(cnt_acc1_r, acc1_s);
            cnt_lost_r <= sat_inc(cnt_lost_r, lost_s);
        end
    end

    assign mpc_vpf      = vpf_r;
    assign mpc_accept   = accept_r;
    assign mpc_reserved = reserved_r;
    assign link_up      = link_up_r;
    assign cnt_xmit     = cnt_xmit_r;
    assign cnt_acc0     = cnt_acc0_r;
    assign cnt_acc1     = cnt_acc1_r;
    assign cnt_lost     = cnt_lost_r;

endmodule
